// File: rtl/lsu_ctrl.sv
// Load/store unit: decodes a core load/store, runs one request/ack
// transaction on a single-port data memory with a timeout, and returns
// extended load data (or an error code) over a valid/ready response.
module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB  = XLEN / 8;
  localparam int LNW = $clog2(NB);
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t            r_state, w_next;
  logic              r_store;
  logic [2:0]        r_f3;
  logic [LNW-1:0]    r_lane;
  logic [CW-1:0]     r_cnt;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic [1:0]        r_rsp_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [NB-1:0]     r_mem_wstrb;
  logic [XLEN-1:0]   r_mem_wdata;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misal;
  logic [LNW-1:0]    w_lane;
  logic [NB-1:0]     w_strb;
  logic [XLEN-1:0]   w_wdata;
  logic [ADDR_W-1:0] w_waddr;
  logic [XLEN-1:0]   w_shr;
  logic [XLEN-1:0]   w_ldata;
  logic              w_tmo;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_lane    = req_addr[LNW-1:0];
  assign w_waddr   = req_addr & ~ADDR_W'(NB - 1);
  assign w_wdata   = req_wdata << {w_lane, 3'b000};
  assign w_shr     = mem_rdata >> {r_lane, 3'b000};
  assign w_tmo     = (r_state == S_ACCESS) && !mem_ack && (r_cnt == CW'(TIMEOUT - 1));

  // Request decode: legality, alignment and byte strobes from funct3 size bits
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    w_strb    = '0;
    if (XLEN == 32)
      w_illegal = req_store ? (req_funct3 > 3'd2)
                            : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    else
      w_illegal = req_store ? (req_funct3 > 3'd3) : (req_funct3 == 3'd7);
    case (req_funct3[1:0])
      2'd0: begin w_misal = 1'b0;               w_strb = NB'(4'h1) << w_lane; end
      2'd1: begin w_misal = req_addr[0];        w_strb = NB'(4'h3) << w_lane; end
      2'd2: begin w_misal = |req_addr[1:0];     w_strb = NB'(4'hF) << w_lane; end
      default: begin w_misal = |req_addr[2:0];  w_strb = '1; end
    endcase
  end

  // Load data: lane-shifted read word, sign- or zero-extended by funct3
  always_comb begin
    w_ldata = w_shr;
    case (r_f3)
      3'b000:  w_ldata = XLEN'($signed(w_shr[7:0]));
      3'b001:  w_ldata = XLEN'($signed(w_shr[15:0]));
      3'b010:  w_ldata = XLEN'($signed(w_shr[31:0]));
      3'b100:  w_ldata = XLEN'(w_shr[7:0]);
      3'b101:  w_ldata = XLEN'(w_shr[15:0]);
      3'b110:  w_ldata = XLEN'(w_shr[31:0]);
      default: w_ldata = w_shr;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and request handshake
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (w_illegal || w_misal) ? S_RESPOND : S_ACCESS;
      end
      S_ACCESS:  if (mem_ack || w_tmo) w_next = S_RESPOND;
      S_RESPOND: if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: capture request, drive memory, build and hold the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store     <= 1'b0;
      r_f3        <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_store <= req_store;
      r_f3    <= req_funct3;
      r_lane  <= w_lane;
      r_cnt   <= '0;
      if (w_illegal || w_misal) begin
        // Error responses go straight out without touching memory
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_illegal ? ERR_ILL : ERR_MIS;
        r_rsp_rdata <= '0;
      end else begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= req_store;
        r_mem_addr  <= w_waddr;
        r_mem_wstrb <= req_store ? w_strb  : '0;
        r_mem_wdata <= req_store ? w_wdata : '0;
      end
    end else if (r_state == S_ACCESS) begin
      if (mem_ack) begin
        // An ack in the final allowed cycle still counts as success
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= ERR_OK;
        r_rsp_rdata <= r_store ? '0 : w_ldata;
        r_cnt       <= '0;
      end else if (w_tmo) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= ERR_TMO;
        r_rsp_rdata <= '0;
        r_cnt       <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (r_state == S_RESPOND && rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;

endmodule
